// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, one-word-per-line, write-through /
// no-write-allocate data cache controller sitting between a CPU memory stage
// and a handshaked backing memory. All state changes on the falling clock
// edge so the rising-edge CPU pipeline sees settled stall/data values.
//
// Ports
//   clk, rst        clock (state on negedge), asynchronous active-high reset
//   cpu_addr        byte address of the load/store
//   cpu_wdata       store data (bits [7:0] for byte stores)
//   cpu_re, cpu_we  load / store request (store wins if both are set)
//   cpu_byte        1 = byte access (lbu/sb), 0 = word access
//   cpu_rdata       load data (0 when no load completes this cycle)
//   stall           CPU must freeze and hold its request
//   mem_req/mem_we  registered backing-memory request / write select
//   mem_addr        word-aligned request address
//   mem_wdata       write data (byte replicated on byte stores)
//   mem_wstrb       byte-lane write enables
//   mem_ack         one-cycle completion pulse
//   mem_rdata       read word, valid with mem_ack
module dcache_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int LINES      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   cpu_addr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   input  logic                    cpu_re,
   input  logic                    cpu_we,
   input  logic                    cpu_byte,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   output logic                    stall,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [DATA_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic                    mem_ack,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = DATA_WIDTH - 2 - IDX_W;
   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t                  state;
   logic [LINES-1:0]        valid;
   logic                    write_done;   // marks the IDLE cycle that retires a held store
   logic [TAG_W-1:0]        tag_mem  [LINES];
   logic [DATA_WIDTH-1:0]   data_mem [LINES];

   logic [IDX_W-1:0]        cpu_idx;
   logic [TAG_W-1:0]        cpu_tag;
   logic [DATA_WIDTH-1:0]   cpu_line;
   logic                    cpu_hit;
   logic [7:0]              lane_byte;

   // mem_addr doubles as the latched request address while FILL/WRITE run.
   logic [IDX_W-1:0]        lat_idx;
   logic [TAG_W-1:0]        lat_tag;
   logic [DATA_WIDTH-1:0]   lat_line;
   logic                    lat_hit;
   logic [DATA_WIDTH-1:0]   merged;

   logic [STRB_W-1:0]       strb;
   logic [DATA_WIDTH-1:0]   wdata_out;
   logic                    idle_active;
   logic                    store_start;
   logic                    load_hit;
   logic                    load_miss;
   logic                    fill_wr;
   logic                    write_wr;

   assign cpu_idx   = cpu_addr[2 +: IDX_W];
   assign cpu_tag   = cpu_addr[DATA_WIDTH-1 -: TAG_W];
   assign cpu_line  = data_mem[cpu_idx];
   assign cpu_hit   = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
   assign lane_byte = cpu_line[{cpu_addr[1:0], 3'b000} +: 8];

   assign lat_idx  = mem_addr[2 +: IDX_W];
   assign lat_tag  = mem_addr[DATA_WIDTH-1 -: TAG_W];
   assign lat_line = data_mem[lat_idx];
   assign lat_hit  = valid[lat_idx] && (tag_mem[lat_idx] == lat_tag);

   assign wdata_out = cpu_byte ? {STRB_W{cpu_wdata[7:0]}} : cpu_wdata;

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_lane
         assign strb[gi] = !cpu_byte || (cpu_addr[1:0] == 2'(gi));
         assign merged[gi*8 +: 8] = mem_wstrb[gi] ? mem_wdata[gi*8 +: 8]
                                                  : lat_line[gi*8 +: 8];
      end
   endgenerate

   // Gating with rst keeps stall/cpu_rdata low for the whole reset pulse,
   // even if the CPU is still presenting a request.
   assign idle_active = (state == IDLE) && !rst;
   assign store_start = idle_active && cpu_we && !write_done;
   assign load_hit    = idle_active && cpu_re && !cpu_we && cpu_hit;
   assign load_miss   = idle_active && cpu_re && !cpu_we && !cpu_hit;

   assign stall     = (!rst && state != IDLE) || store_start || load_miss;
   assign cpu_rdata = !load_hit ? '0
                    : cpu_byte  ? {{(DATA_WIDTH-8){1'b0}}, lane_byte}
                    : cpu_line;

   assign fill_wr  = (state == FILL)  && mem_ack;
   assign write_wr = (state == WRITE) && mem_ack && lat_hit;

   // Line storage: no reset needed, the valid bits qualify every entry.
   always_ff @(negedge clk) begin
      if (fill_wr) begin
         data_mem[lat_idx] <= mem_rdata;
         tag_mem[lat_idx]  <= lat_tag;
      end else if (write_wr) begin
         data_mem[lat_idx] <= merged;
      end
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= '0;
         write_done <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               write_done <= 1'b0;
               if (store_start || load_miss) begin
                  state     <= store_start ? WRITE : FILL;
                  mem_req   <= 1'b1;
                  mem_we    <= store_start;
                  mem_addr  <= {cpu_addr[DATA_WIDTH-1:2], 2'b00};
                  mem_wdata <= wdata_out;
                  mem_wstrb <= strb;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  valid[lat_idx] <= 1'b1;
                  state          <= IDLE;
                  mem_req        <= 1'b0;
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  state      <= IDLE;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  write_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
